pmu_mem_arbiter: RTL and testbench
==================================

# pmu_mem_arbiter

Two-port arbiter that shares the PMU's single-port 256x32 data memory (synchronous write, combinational read) between the host configuration bus (port 0) and the PMU sequencer core (port 1). It grants at most one access per cycle with round-robin fairness. It supports a bounded lock so one port can perform atomic read-modify-write sequences. Read data is registered and returned one cycle after grant. The block sits directly between both requesters and the memory instance; nothing else drives the memory.

## Interface
- AW, 8, memory address width (depth 2^AW words)
- DW, 32, data width
- LOCK_MAX, 16, maximum consecutive cycles a port may hold a lock before forced release (1..255)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN=1
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  hold ownership after this access (atomic sequence)
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  registered read data valid, one cycle after read grant
- rdata0 / rdata1  out  DW  registered read data
- lock_err  out  1  one-cycle pulse: lock forcibly released by LOCK_MAX timeout
- mem_we  out  1  to memory we
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory data_i
- mem_rdata  in  DW  from memory data_o (combinational)

## Operation
- Registered state: prio (next preferred port), owner state, lock counter (8 bits), rvalid/rdata per port, lock_err.
- Owner states: FREE, OWN0, OWN1.
- FREE: if only one port requests, grant it. If both request, grant port prio. After any grant, prio <= other port. If the granted port has lockN=1, go to OWNn and load the counter with 1.
- OWNn: only port n can be granted. The other port's gnt is forced to 0 even if it requests.
  - Counter increments each cycle in OWNn.
  - Go to FREE when port n deasserts lockN, with or without a request that cycle. The access carried with lockN=0 is still granted and is the last locked access.
  - Go to FREE when the counter reaches LOCK_MAX. lock_err pulses in the cycle after the transition, and prio <= the other port.
- Mux: mem_addr/mem_wdata/mem_we come from the granted port. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read grant: rdataN <= mem_rdata at the grant edge, rvalidN <= 1 for exactly one cycle.
- Write grant: memory is updated at the grant edge. rvalidN stays 0.
- rdataN holds its value until the next read grant to that port.
- Requesters hold req/we/addr/wdata/lock stable until gnt=1. The arbiter never drops a granted access.

## Timing
- Reset values (async, while rst_n=0): gnt0=gnt1=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid0=rvalid1=0, rdata0=rdata1=0, lock_err=0, state=FREE, prio=port 0, counter=0.
- gnt is combinational from req and registered state. Throughput is one access per cycle, total.
- Read latency: data is on rdataN with rvalidN=1 in the cycle after the gnt cycle.
- A write followed by a read of the same address in the next cycle returns the new data.
- Back-to-back requests from both ports alternate 0,1,0,1 starting from the current prio.
- Reset asserted mid-access: the access is abandoned, pending rvalid is cleared, the lock is dropped. Memory contents are not cleared by this block.
- Lock held continuously: the other port waits at most LOCK_MAX+1 cycles for a grant.

## Test plan
- Reset, then single requester: req0=1, we0=1, addr0=8'h10, wdata0=32'hDEADBEEF. Next cycle: req0=1, we0=0, addr0=8'h10. Required: gnt0=1 both cycles; the cycle after the read shows rvalid0=1, rdata0=32'hDEADBEEF; rvalid1 stays 0.
- Contention: req0=req1=1 for 4 cycles, reads at 8'h01/8'h02, after reset. Required: gnt sequence 0,1,0,1; each rvalid is a single-cycle pulse one cycle after the matching gnt.
- Atomic RMW: port 1 reads 8'h20 with lock1=1, then writes 8'h20 with lock1=0, while req0=1 throughout. Required: gnt0=0 during both port-1 accesses; gnt0=1 in the following cycle; state returns to FREE.
- Lock timeout with LOCK_MAX=4: port 0 holds lock0=1 and req0=1 indefinitely; req1=1. Required: gnt1=1 no later than cycle 5 after the lock is acquired; lock_err is a one-cycle pulse; port 0 is not re-granted before port 1.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant. Required: rvalid0=0 and rdata0=0 immediately (asynchronous); after release, state=FREE and prio=port 0.
- Idle: req0=req1=0 for 10 cycles. Required: mem_we=0, mem_addr=0, no rvalid pulses, memory contents unchanged.

Source files
------------

// File: rtl/pmu_mem_arbiter.sv
// Round-robin arbiter sharing the PMU single-port data memory between the host bus (port 0)
// and the sequencer (port 1), with a bounded ownership lock for atomic read-modify-write.
module pmu_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          lock_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Handshake: a request is held stable until gnt; gnt in a cycle means the access is
    // performed at the next rising edge, and read data follows with rvalid one cycle later.

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_e;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    own_e       state, state_d;
    logic       prio, prio_d;
    logic [7:0] cnt, cnt_d;
    logic       force_rel;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_d   = state;
        prio_d    = prio;
        cnt_d     = cnt;
        force_rel = 1'b0;
        if (rst_n) begin
            case (state)
                FREE: begin
                    if (req0 && (!req1 || !prio)) gnt0 = 1'b1;
                    else if (req1)                gnt1 = 1'b1;
                    if (gnt0) begin
                        prio_d = 1'b1;
                        if (lock0) begin
                            state_d = OWN0;
                            cnt_d   = 8'd1;
                        end
                    end
                    if (gnt1) begin
                        prio_d = 1'b0;
                        if (lock1) begin
                            state_d = OWN1;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                OWN0: begin
                    gnt0  = req0;
                    cnt_d = cnt + 8'd1;
                    if (gnt0) prio_d = 1'b1;
                    // A voluntary release wins over a timeout in the same cycle.
                    if (!lock0) begin
                        state_d = FREE;
                        cnt_d   = 8'd0;
                    end else if (cnt >= LOCK_LIMIT) begin
                        state_d   = FREE;
                        cnt_d     = 8'd0;
                        prio_d    = 1'b1;
                        force_rel = 1'b1;
                    end
                end
                OWN1: begin
                    gnt1  = req1;
                    cnt_d = cnt + 8'd1;
                    if (gnt1) prio_d = 1'b0;
                    if (!lock1) begin
                        state_d = FREE;
                        cnt_d   = 8'd0;
                    end else if (cnt >= LOCK_LIMIT) begin
                        state_d   = FREE;
                        cnt_d     = 8'd0;
                        prio_d    = 1'b0;
                        force_rel = 1'b1;
                    end
                end
                default: begin
                    state_d = FREE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FREE;
            prio     <= 1'b0;
            cnt      <= 8'd0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_d;
            prio     <= prio_d;
            cnt      <= cnt_d;
            lock_err <= force_rel;
            rvalid0  <= gnt0 && !we0;
            rvalid1  <= gnt1 && !we1;
            if (gnt0 && !we0) rdata0 <= mem_rdata;
            if (gnt1 && !we1) rdata1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_pmu_mem_arbiter.sv
// Directed bench for pmu_mem_arbiter: grant sequences checked per cycle, read data checked
// by a scoreboard monitor against an expected queue per port.
module tb_pmu_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, lock_err;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] snap [256];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          total;
    int          bad;

    pmu_mem_arbiter #(.AW(8), .DW(32), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .lock_err(lock_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, 8'(i)};
    end
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    task automatic run_monitor();
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (rvalid0 === 1'b1) begin
                    if (exp_q0.size() == 0) chk("rvalid0_unexpected", 32'(rvalid0), 32'd0);
                    else chk("rdata0", rdata0, exp_q0.pop_front());
                end
                if (rvalid1 === 1'b1) begin
                    if (exp_q1.size() == 0) chk("rvalid1_unexpected", 32'(rvalid1), 32'd0);
                    else chk("rdata1", rdata1, exp_q1.pop_front());
                end
            end
        end
    endtask

    // drivers
    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic step(input logic e0, input logic e1, input logic ele, input string name);
        @(negedge clk);
        chk({name, ":gnt0"}, 32'(gnt0), 32'(e0));
        chk({name, ":gnt1"}, 32'(gnt1), 32'(e1));
        chk({name, ":lock_err"}, 32'(lock_err), 32'(ele));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int diff;
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_n = 1'b0;
        fork
            run_monitor();
        join_none

        // reset values, with a request pending during reset
        req0 = 1; we0 = 1; addr0 = 8'h55; wdata0 = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst:gnt0", 32'(gnt0), 32'd0);
        chk("rst:gnt1", 32'(gnt1), 32'd0);
        chk("rst:mem_we", 32'(mem_we), 32'd0);
        chk("rst:mem_addr", 32'(mem_addr), 32'd0);
        chk("rst:mem_wdata", mem_wdata, 32'd0);
        chk("rst:rvalid0", 32'(rvalid0), 32'd0);
        chk("rst:rvalid1", 32'(rvalid1), 32'd0);
        chk("rst:rdata0", rdata0, 32'd0);
        chk("rst:rdata1", rdata1, 32'd0);
        chk("rst:lock_err", 32'(lock_err), 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;

        // single requester: write then read back
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
        step(1, 0, 0, "t1_wr");
        we0 = 0;
        exp_q0.push_back(32'hDEADBEEF);
        step(1, 0, 0, "t1_rd");
        clear_inputs();
        step(0, 0, 0, "t1_idle");

        // contention from reset: 0,1,0,1
        do_reset();
        req0 = 1; addr0 = 8'h01; req1 = 1; addr1 = 8'h02;
        exp_q0.push_back(32'hA5A5A501); exp_q0.push_back(32'hA5A5A501);
        exp_q1.push_back(32'hA5A5A502); exp_q1.push_back(32'hA5A5A502);
        step(1, 0, 0, "rr_c0");
        step(0, 1, 0, "rr_c1");
        step(1, 0, 0, "rr_c2");
        step(0, 1, 0, "rr_c3");
        clear_inputs();
        step(0, 0, 0, "rr_idle");

        // atomic read-modify-write by port 1 while port 0 keeps requesting
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 32'h00000100;
        step(1, 0, 0, "rmw_seed");
        we0 = 0; addr0 = 8'h30;
        req1 = 1; we1 = 0; addr1 = 8'h20; lock1 = 1;
        exp_q1.push_back(32'h00000100);
        step(0, 1, 0, "rmw_rd");
        we1 = 1; wdata1 = 32'h00000101; lock1 = 0;
        step(0, 1, 0, "rmw_wr");
        req1 = 0; we1 = 0;
        exp_q0.push_back(32'hA5A5A530);
        step(1, 0, 0, "rmw_after");
        addr0 = 8'h20;
        exp_q0.push_back(32'h00000101);
        step(1, 0, 0, "rmw_chk");
        clear_inputs();
        step(0, 0, 0, "rmw_idle");
        req1 = 1; addr1 = 8'h02;
        exp_q1.push_back(32'hA5A5A502);
        step(0, 1, 0, "rmw_free");
        clear_inputs();
        step(0, 0, 0, "rmw_idle2");

        // lock timeout with LOCK_MAX=4
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 32'h40404040; lock0 = 1;
        step(1, 0, 0, "lk_acq");
        req1 = 1; we1 = 0; addr1 = 8'h02;
        for (int i = 0; i < 4; i++) step(1, 0, 0, "lk_hold");
        exp_q1.push_back(32'hA5A5A502);
        step(0, 1, 1, "lk_tmo");
        req1 = 0;
        step(1, 0, 0, "lk_regrant");
        lock0 = 0;
        step(1, 0, 0, "lk_rel");
        clear_inputs();
        step(0, 0, 0, "lk_idle");

        // reset in the cycle after a read grant
        req0 = 1; we0 = 0; addr0 = 8'h10;
        step(1, 0, 0, "mr_rd");
        clear_inputs();
        chk("mr:rvalid0_pre", 32'(rvalid0), 32'd1);
        chk("mr:rdata0_pre", rdata0, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("mr:rvalid0_async", 32'(rvalid0), 32'd0);
        chk("mr:rdata0_async", rdata0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0 = 1; addr0 = 8'h01; req1 = 1; addr1 = 8'h02;
        exp_q0.push_back(32'hA5A5A501);
        exp_q1.push_back(32'hA5A5A502);
        step(1, 0, 0, "mr_prio0");
        step(0, 1, 0, "mr_prio1");
        clear_inputs();
        step(0, 0, 0, "mr_idle");

        // idle: no memory traffic
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle:mem_we", 32'(mem_we), 32'd0);
            chk("idle:mem_addr", 32'(mem_addr), 32'd0);
            @(posedge clk);
            #1;
        end
        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diff++;
        chk("idle:mem_unchanged", 32'(diff), 32'd0);

        chk("end:q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("end:q1_empty", 32'(exp_q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
